// File: rtl/vga_text_pkg.sv
// Shared types and constants for the hardware text console that drives the
// VGA text buffer through the main_clk I/O port.
package vga_text_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PUT    = 3'd1,
        SCR_RD = 3'd2,
        SCR_W1 = 3'd3,
        SCR_W2 = 3'd4,
        SCR_WR = 3'd5,
        CLR    = 3'd6
    } state_t;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    localparam int CELL_BYTES        = 3;
    localparam int VGA_RESERVED_BASE = 20476;

    // 0x7F (DEL) is the only code at or above 0x20 that is not drawn
    function automatic logic is_printable(input logic [7:0] c);
        return ((c >= 8'h20) && (c <= 8'h7E)) || c[7];
    endfunction

endpackage

// File: rtl/vga_text_console.sv
// Byte-stream text terminal: cursor tracking, 3-byte cell writes, control codes
// and word-copy scrolling, acting as an initiator on the VGA memory I/O port.
module vga_text_console
    import vga_text_pkg::*;
#(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int TEXT_BASE = 0
) (
    input  logic        main_clk,
    input  logic        rst_n,
    input  logic        char_valid,
    output logic        char_ready,
    input  logic [7:0]  char_data,
    input  logic [7:0]  color_fg,
    input  logic [7:0]  color_bg,
    output logic        io_req,
    input  logic        io_gnt,
    output logic        io_do_write,
    output logic        io_do_byte_op,
    output logic [14:0] io_addr,
    output logic [15:0] io_write_data,
    input  logic [15:0] io_read_data,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam int          ROW_BYTES  = COLS * CELL_BYTES;
    localparam logic [14:0] BASE_A     = 15'(TEXT_BASE);
    localparam logic [14:0] ROW_A      = 15'(ROW_BYTES);
    localparam logic [14:0] LAST_ROW_A = 15'(TEXT_BASE + (ROWS - 1) * ROW_BYTES);
    localparam logic [14:0] LAST_DST_A = LAST_ROW_A - 15'd2;
    localparam logic [14:0] END_A      = 15'(TEXT_BASE + ROWS * ROW_BYTES - 1);
    localparam logic [6:0]  COL_LAST   = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST   = 5'(ROWS - 1);

    state_t      state;
    logic [1:0]  phase;
    logic [14:0] addr;
    logic [6:0]  col;
    logic [4:0]  row;
    logic [7:0]  ch, fg, bg;
    logic [15:0] word;
    logic        rdy_en;

    logic        accept;
    logic        wr_phase;
    logic [14:0] cell_addr;
    logic [14:0] addr_sum;
    logic [7:0]  cur_byte;

    assign accept    = char_valid & char_ready;
    assign cell_addr = 15'(TEXT_BASE + CELL_BYTES * (int'(row) * COLS + int'(col)));
    // Single incrementer serves cell bytes, clear bytes and scroll words
    assign addr_sum  = addr + ((state == SCR_WR) ? 15'd2 : 15'd1);

    always_comb begin
        cur_byte = bg;
        case (phase)
            2'd0:    cur_byte = (state == PUT) ? ch : CH_SPACE;
            2'd1:    cur_byte = fg;
            default: cur_byte = bg;
        endcase
    end

    always_comb begin
        io_req        = (state == PUT) || (state == SCR_RD) || (state == SCR_WR) || (state == CLR);
        wr_phase      = (state == PUT) || (state == SCR_WR) || (state == CLR);
        io_do_write   = io_req & io_gnt & wr_phase;
        io_do_byte_op = (state == PUT) || (state == CLR);
        io_addr       = (state == SCR_RD) ? addr + ROW_A : addr;
        io_write_data = 16'h0000;
        if (io_do_byte_op)
            io_write_data = {cur_byte, cur_byte};
        else if (state == SCR_WR)
            io_write_data = word;
    end

    assign char_ready = rdy_en & (state == IDLE);
    assign busy       = (state != IDLE);
    assign cursor_col = col;
    assign cursor_row = row;

    always_ff @(posedge main_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            phase  <= 2'd0;
            addr   <= 15'd0;
            col    <= 7'd0;
            row    <= 5'd0;
            ch     <= 8'h00;
            fg     <= 8'h00;
            bg     <= 8'h00;
            word   <= 16'h0000;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: if (accept) begin
                    ch <= char_data;
                    fg <= color_fg;
                    bg <= color_bg;
                    if (is_printable(char_data)) begin
                        state <= PUT;
                        phase <= 2'd0;
                        addr  <= cell_addr;
                    end else if (char_data == CH_LF) begin
                        col <= 7'd0;
                        if (row < ROW_LAST) begin
                            row <= row + 5'd1;
                        end else begin
                            state <= SCR_RD;
                            addr  <= BASE_A;
                        end
                    end else if (char_data == CH_CR) begin
                        col <= 7'd0;
                    end else if (char_data == CH_BS) begin
                        if (col != 7'd0) col <= col - 7'd1;
                    end else if (char_data == CH_FF) begin
                        state <= CLR;
                        phase <= 2'd0;
                        addr  <= BASE_A;
                    end
                end
                PUT: if (io_gnt) begin
                    addr <= addr_sum;
                    if (phase == 2'd2) begin
                        phase <= 2'd0;
                        state <= IDLE;
                        if (col == COL_LAST) begin
                            col <= 7'd0;
                            if (row < ROW_LAST) begin
                                row <= row + 5'd1;
                            end else begin
                                // cell already written, so it scrolls up with its row
                                state <= SCR_RD;
                                addr  <= BASE_A;
                            end
                        end else begin
                            col <= col + 7'd1;
                        end
                    end else begin
                        phase <= phase + 2'd1;
                    end
                end
                SCR_RD: if (io_gnt) state <= SCR_W1;
                SCR_W1: state <= SCR_W2;
                SCR_W2: begin
                    word  <= io_read_data;
                    state <= SCR_WR;
                end
                SCR_WR: if (io_gnt) begin
                    if (addr == LAST_DST_A) begin
                        state <= CLR;
                        phase <= 2'd0;
                        addr  <= LAST_ROW_A;
                    end else begin
                        addr  <= addr_sum;
                        state <= SCR_RD;
                    end
                end
                CLR: if (io_gnt) begin
                    addr  <= addr_sum;
                    phase <= (phase == 2'd2) ? 2'd0 : phase + 2'd1;
                    if (addr == END_A) begin
                        state <= IDLE;
                        phase <= 2'd0;
                        col   <= 7'd0;
                        if (ch == CH_FF) row <= 5'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_console.sv
// Self-checking bench: behavioural screen model vs. a bus-slave memory image,
// with randomized characters, colours and grant patterns.
module tb_vga_text_console;

    localparam int COLS      = 80;
    localparam int ROWS      = 30;
    localparam int ROW_BYTES = COLS * 3;
    localparam int SCREEN    = ROWS * ROW_BYTES;
    localparam int MEM       = 20476;

    logic        main_clk, rst_n;
    logic        char_valid, char_ready;
    logic [7:0]  char_data, color_fg, color_bg;
    logic        io_req, io_gnt, io_do_write, io_do_byte_op;
    logic [14:0] io_addr;
    logic [15:0] io_write_data, io_read_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    vga_text_console #(.COLS(COLS), .ROWS(ROWS), .TEXT_BASE(0)) dut (
        .main_clk(main_clk), .rst_n(rst_n),
        .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
        .color_fg(color_fg), .color_bg(color_bg),
        .io_req(io_req), .io_gnt(io_gnt), .io_do_write(io_do_write),
        .io_do_byte_op(io_do_byte_op), .io_addr(io_addr),
        .io_write_data(io_write_data), .io_read_data(io_read_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy)
    );

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    typedef struct { int addr; logic [15:0] data; } wr_t;

    logic [7:0] mem [0:MEM-1];
    logic [7:0] ref_mem [0:SCREEN-1];
    int rcol, rrow;
    int total, bad;
    int n_wr, n_rd, n_wr_word, first_rd_addr, first_wr_addr, last_wr_addr;
    int rd_a;
    int gnt_mode;
    wr_t wr_q[$];
    logic        p_den;
    logic [14:0] p_addr;
    logic [15:0] p_wd;

    initial begin
        total = 0; bad = 0; n_wr = 0; n_rd = 0; n_wr_word = 0;
        first_rd_addr = -1; first_wr_addr = -1; last_wr_addr = -1; rd_a = 0; p_den = 1'b0;
    end

    assign io_read_data = {mem[rd_a + 1], mem[rd_a]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // grant driver
    initial begin
        io_gnt = 1'b0;
        forever begin
            @(posedge main_clk); #1;
            case (gnt_mode)
                0:       io_gnt = 1'b1;
                1:       io_gnt = ($urandom % 4) != 0;
                2:       io_gnt = ~io_gnt;
                default: io_gnt = 1'b0;
            endcase
        end
    end

    // bus slave memory plus hold-while-denied checks
    always @(negedge main_clk) begin
        if (rst_n && p_den) begin
            chk("hold_req", io_req, 1);
            chk("hold_addr", io_addr, p_addr);
            chk("hold_wdata", io_write_data, p_wd);
        end
        p_den  = rst_n && io_req && !io_gnt;
        p_addr = io_addr;
        p_wd   = io_write_data;
        if (rst_n && io_req && io_gnt) begin
            chk("addr_range", int'(io_addr) < MEM - 1, 1);
            if (int'(io_addr) < MEM - 1) begin
                if (io_do_write) begin
                    n_wr++;
                    if (io_do_byte_op) begin
                        chk("byte_replicate", io_write_data[15:8], io_write_data[7:0]);
                        mem[io_addr] = io_write_data[7:0];
                        wr_q.push_back('{int'(io_addr), io_write_data});
                    end else begin
                        mem[io_addr]     = io_write_data[7:0];
                        mem[io_addr + 1] = io_write_data[15:8];
                        n_wr_word++;
                        if (n_wr_word == 1) first_wr_addr = int'(io_addr);
                        last_wr_addr = int'(io_addr);
                    end
                end else begin
                    n_rd++;
                    if (n_rd == 1) first_rd_addr = int'(io_addr);
                    rd_a = int'(io_addr);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit drawn(input logic [7:0] c);
        return (c >= 8'h20) && (c != 8'h7F);
    endfunction

    task automatic model_newline(input logic [7:0] f, input logic [7:0] b);
        if (rrow < ROWS - 1) begin
            rrow++;
        end else begin
            for (int i = 0; i < SCREEN - ROW_BYTES; i++) ref_mem[i] = ref_mem[i + ROW_BYTES];
            for (int i = SCREEN - ROW_BYTES; i < SCREEN; i++)
                ref_mem[i] = (i % 3 == 0) ? 8'h20 : ((i % 3 == 1) ? f : b);
        end
    endtask

    task automatic model_char(input logic [7:0] c, input logic [7:0] f, input logic [7:0] b);
        int p;
        if (drawn(c)) begin
            p = 3 * (rrow * COLS + rcol);
            ref_mem[p] = c; ref_mem[p + 1] = f; ref_mem[p + 2] = b;
            rcol++;
            if (rcol == COLS) begin
                rcol = 0;
                model_newline(f, b);
            end
        end else if (c == 8'h0A) begin
            rcol = 0;
            model_newline(f, b);
        end else if (c == 8'h0D) begin
            rcol = 0;
        end else if (c == 8'h08) begin
            if (rcol > 0) rcol--;
        end else if (c == 8'h0C) begin
            for (int i = 0; i < SCREEN; i++)
                ref_mem[i] = (i % 3 == 0) ? 8'h20 : ((i % 3 == 1) ? f : b);
            rcol = 0; rrow = 0;
        end
    endtask

    task automatic check_screen(input string tag);
        int diffs = 0;
        for (int i = 0; i < SCREEN; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk({tag, "_mem_diffs"}, diffs, 0);
        chk({tag, "_col"}, cursor_col, rcol);
        chk({tag, "_row"}, cursor_row, rrow);
    endtask

    // offer one byte, return the cycle (after accept) in which char_ready returns
    task automatic send(input logic [7:0] c, input logic [7:0] f, input logic [7:0] b, output int cyc);
        int w = 0;
        @(posedge main_clk); #1;
        char_valid = 1'b1; char_data = c; color_fg = f; color_bg = b;
        while (w <= 50000) begin
            @(negedge main_clk);
            if (char_ready) break;
            w++;
        end
        if (w > 50000) chk("accept_timeout", 0, 1);
        @(posedge main_clk); #1;
        char_valid = 1'b0; char_data = 8'($urandom);
        cyc = 0;
        do begin
            @(negedge main_clk);
            cyc++;
        end while (!char_ready && cyc < 50000);
        if (cyc >= 50000) chk("ready_timeout", 0, 1);
        model_char(c, f, b);
    endtask

    function automatic logic [7:0] rnd_print();
        logic [7:0] c = 8'($urandom_range(32, 255));
        return (c == 8'h7F) ? 8'h41 : c;
    endfunction

    initial begin
        int cyc, snap;
        logic [7:0] c, f, b;
        rst_n = 1'b0; char_valid = 1'b0; char_data = 8'h00; color_fg = 8'h00; color_bg = 8'h00;
        gnt_mode = 0;
        for (int i = 0; i < MEM; i++) begin
            mem[i] = 8'($urandom);
            if (i < SCREEN) ref_mem[i] = mem[i];
        end
        rcol = 0; rrow = 0;

        repeat (3) @(posedge main_clk);
        @(negedge main_clk);
        chk("rst_char_ready", char_ready, 0);
        chk("rst_io_req", io_req, 0);
        chk("rst_io_do_write", io_do_write, 0);
        chk("rst_byte_op", io_do_byte_op, 0);
        chk("rst_io_addr", io_addr, 0);
        chk("rst_wdata", io_write_data, 0);
        chk("rst_cursor", {cursor_row, cursor_col}, 0);
        chk("rst_busy", busy, 0);
        @(posedge main_clk); #1 rst_n = 1'b1;
        @(negedge main_clk);
        chk("ready_before_edge", char_ready, 0);
        @(negedge main_clk);
        chk("ready_after_edge", char_ready, 1);

        // first character, grant held
        wr_q.delete();
        send(8'h41, 8'hFF, 8'h03, cyc);
        chk("put_latency", cyc, 4);
        chk("put_nwrites", wr_q.size(), 3);
        if (wr_q.size() == 3) begin
            chk("put_w0_addr", wr_q[0].addr, 0);
            chk("put_w0_data", wr_q[0].data, 16'h4141);
            chk("put_w1", {wr_q[1].addr[15:0], wr_q[1].data}, {16'd1, 16'hFFFF});
            chk("put_w2", {wr_q[2].addr[15:0], wr_q[2].data}, {16'd2, 16'h0303});
        end
        check_screen("first_char");

        // CR: no bus traffic
        snap = n_wr + n_rd;
        send(8'h0D, 8'h11, 8'h22, cyc);
        chk("cr_latency", cyc, 1);
        chk("cr_no_traffic", n_wr + n_rd, snap);
        check_screen("cr");

        // toggling grant during PUT
        gnt_mode = 2;
        wr_q.delete();
        send(8'h42, 8'($urandom), 8'($urandom), cyc);
        chk("toggle_nwrites", wr_q.size(), 3);
        check_screen("toggle");
        gnt_mode = 0;

        // BS at col 1 then at col 0
        send(8'h08, 8'h00, 8'h00, cyc);
        chk("bs_latency", cyc, 1);
        check_screen("bs_col1");
        send(8'h08, 8'h00, 8'h00, cyc);
        check_screen("bs_col0");

        // 80 characters on row 0 with random grant
        gnt_mode = 1;
        wr_q.delete();
        for (int i = 0; i < COLS; i++) send(rnd_print(), 8'($urandom), 8'($urandom), cyc);
        chk("row0_last_cell", wr_q[$].addr, 239);
        chk("row0_last_cell_start", wr_q[$-2].addr, 237);
        check_screen("row0_fill");

        // mixed random stream
        for (int i = 0; i < 150; i++) begin
            int r = $urandom % 10;
            f = 8'($urandom); b = 8'($urandom);
            if (r == 0 && rrow < ROWS - 3) c = 8'h0A;
            else if (r == 1) c = 8'h0D;
            else if (r == 2) c = 8'h08;
            else if (r == 3) begin
                c = 8'($urandom_range(0, 31));
                if (c == 8'h0A || c == 8'h0D || c == 8'h08 || c == 8'h0C) c = 8'h1B;
            end else c = rnd_print();
            send(c, f, b, cyc);
        end
        check_screen("mixed");

        // form feed
        gnt_mode = 0;
        send(8'h0C, 8'h5A, 8'hA5, cyc);
        chk("ff_latency", cyc, SCREEN + 1);
        check_screen("ff");

        // move to (5,29), then LF triggers a full scroll
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 8'h00, 8'h00, cyc);
        for (int i = 0; i < 5; i++) send(rnd_print(), 8'($urandom), 8'($urandom), cyc);
        check_screen("pre_scroll");
        n_rd = 0; n_wr_word = 0;
        send(8'h0A, 8'h3C, 8'hC3, cyc);
        chk("scroll_latency", cyc, 1 + 4 * 3480 + ROW_BYTES);
        chk("scroll_reads", n_rd, 3480);
        chk("scroll_word_writes", n_wr_word, 3480);
        chk("scroll_first_rd", first_rd_addr, 240);
        chk("scroll_first_wr", first_wr_addr, 0);
        chk("scroll_last_wr", last_wr_addr, 6958);
        check_screen("scroll_lf");

        // wrap at the last row with random grant
        for (int i = 0; i < COLS - 1; i++) send(rnd_print(), 8'($urandom), 8'($urandom), cyc);
        gnt_mode = 1;
        send(rnd_print(), 8'($urandom), 8'($urandom), cyc);
        check_screen("scroll_wrap");

        // reset in the middle of a scroll
        gnt_mode = 0;
        @(posedge main_clk); #1;
        char_valid = 1'b1; char_data = 8'h0A;
        @(negedge main_clk);
        chk("mid_rst_ready", char_ready, 1);
        @(posedge main_clk); #1 char_valid = 1'b0;
        repeat (1000) @(posedge main_clk);
        #3;
        chk("mid_rst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", io_req, 0);
        chk("mid_rst_do_write", io_do_write, 0);
        chk("mid_rst_byte_op", io_do_byte_op, 0);
        chk("mid_rst_addr", io_addr, 0);
        chk("mid_rst_wdata", io_write_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready_low", char_ready, 0);
        chk("mid_rst_cursor", {cursor_row, cursor_col}, 0);
        snap = n_wr;
        repeat (5) @(posedge main_clk);
        #1 rst_n = 1'b1;
        @(negedge main_clk);
        @(negedge main_clk);
        chk("post_rst_ready", char_ready, 1);
        repeat (10) @(posedge main_clk);
        chk("post_rst_no_writes", n_wr, snap);
        chk("post_rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
